matrix_result_collector: RTL
============================

# matrix_result_collector

Downstream stage of the matrix multiplier handler. Captures each `(result, res_i, res_j)` triple on `res_ack` into an `r_a × c_b` result buffer, in any arrival order. Once every element has been written, it streams the buffer out row-major over a valid/ready interface. It flags out-of-range indices and late writes, and holds `done` until cleared.

## Interface
Parameters:
- `r_a`, default 2: result rows.
- `c_b`, default 2: result columns.
- `W`, default 32: result word width.

Ports:
- `clk`  in  1: single clock; all logic is on the rising edge.
- `rst`  in  1: reset, synchronous and active-high.
- `clear`  in  1: synchronous soft restart; same effect as `rst`.
- `res_ack`  in  1: result strobe from the multiplier; one element per high cycle.
- `result`  in  W: result value, signed, stored verbatim.
- `res_i`  in  32: row index.
- `res_j`  in  32: column index.
- `out_valid`  out  1: `out_data` is valid.
- `out_ready`  in  1: consumer accepts the current word.
- `out_data`  out  W: buffer word at the read pointer.
- `out_row`  out  32: row of the current word.
- `out_col`  out  32: column of the current word.
- `out_last`  out  1: current word is element `(r_a-1, c_b-1)`.
- `done`  out  1: all words have been transferred; sticky.
- `err_range`  out  1: sticky; a `res_ack` arrived with `res_i >= r_a` or `res_j >= c_b`.
- `err_late`  out  1: sticky; a `res_ack` arrived in DRAIN or DONE.
- `fill_count`  out  32: number of distinct elements written.

## Operation
- **States:** COLLECT, DRAIN, DONE.
- **Reset or `clear`:** state goes to COLLECT. The valid bitmap, `fill_count`, read pointer, `done`, `err_range` and `err_late` all go to 0. Buffer contents are don't-care. `rst` and `clear` have priority over every other event in the same cycle, including an in-flight transfer.
- **COLLECT, in-range `res_ack`:**
  - Write `buf[res_i*c_b + res_j] <= result` and set the bitmap bit.
  - `fill_count` increments only if the bit was previously clear.
  - A duplicate overwrites the value without incrementing `fill_count`.
- **COLLECT, out-of-range `res_ack`:** no write; set `err_range`.
- **COLLECT → DRAIN:** on the first edge at which the bitmap is all ones, i.e. the edge after the last distinct write. The read pointer is 0 on entry.
- **DRAIN:**
  - `out_valid` is 1.
  - `out_data = buf[ptr]`, with `out_row = ptr / c_b` and `out_col = ptr % c_b`.
  - A transfer happens on an edge where `out_valid && out_ready`; the pointer then increments.
  - A transfer with `ptr == r_a*c_b-1` moves the state to DONE.
- **DONE:** `done` is 1 and `out_valid` is 0. Hold until `rst` or `clear`.
- **`res_ack` in DRAIN or DONE:** dropped, buffer unchanged, `err_late` set.
- **`out_ready` outside DRAIN:** ignored.

## Timing
- **Reset values:** `out_valid`, `out_last`, `done`, `err_range`, `err_late` = 0; `fill_count` = 0; `out_row`, `out_col` = 0; `out_data` don't-care.
- **Fill latency:** if the final distinct write is captured at edge N, the state is DRAIN and `out_valid` = 1 from edge N+1.
- **Output path:** `out_data`, `out_row`, `out_col` and `out_last` follow the pointer with no extra register stage.
- **Backpressure:** with `out_ready` held high, the block transfers one word per cycle. Back-to-back transfers need no bubbles.
- **Stall:** while `out_ready` is low, all outputs hold stable.
- **Done latency:** the last transfer at edge M gives `done` = 1 from edge M+1.
- **Index arithmetic:** the index is computed in 32 bits and compared before the multiply. No wrap-around is possible for in-range indices.
- **Degenerate size:** with `r_a = c_b = 1`, the first in-range `res_ack` leads to DRAIN one cycle later, and `out_last` = 1 on the only word.

## Structure
- **Shared package:** the state enum (COLLECT/DRAIN/DONE) and a `mat_idx(i, j, cols)` helper function. Both are shared with the handler and the input loaders.
- **Sub-module:** one, `result_bitmap`. It holds the valid bits and the distinct-write counter, and provides a set-with-first-write flag and an all-full output. The buffer array and the FSM stay in the top module.

## Test plan
1. **In-order fill, 2×2:** write values 10, 20, 30, 40 at (0,0), (0,1), (1,0), (1,1) with `out_ready` = 1 → outputs 10, 20, 30, 40 on consecutive cycles, `out_last` on 40, `done` = 1 one cycle later.
2. **Reverse order plus duplicate:** write (1,1)=4, (1,0)=3, (1,1)=9, (0,1)=2, (0,0)=1 → `fill_count` sequence 1, 2, 2, 3, 4; output 1, 2, 3, 9.
3. **Out-of-range write:** `res_i` = 2 with `result` = 77, followed by a valid fill → `err_range` = 1, 77 never appears on the output, drain proceeds normally.
4. **Backpressure:** `out_ready` toggling 1, 0, 0, 1, … → each word held stable while stalled, no word lost or repeated, 4 transfers total.
5. **Late write plus `clear` mid-drain:** `res_ack` during DRAIN → `err_late` = 1 and data unchanged. Then assert `clear` after 2 transfers → next cycle state is COLLECT, `fill_count` = 0, errors cleared; a refill with 5, 6, 7, 8 drains as 5, 6, 7, 8.

Source files
------------

// File: rtl/matrix_result_collector_pkg.sv
`default_nettype none
// ============================================================================
// Module      : matrix_result_collector_pkg
// Description : Shared state encoding and flat-index helper for the matrix
//               multiplier handler, input loaders and result collector.
// Revision    : 1.0 - initial release
// ============================================================================
package matrix_result_collector_pkg;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        DRAIN   = 2'd1,
        DONE    = 2'd2
    } state_t;

    // Row-major flat index of element (i, j) in a matrix with 'cols' columns.
    function automatic logic [31:0] mat_idx(
        input logic [31:0] i,
        input logic [31:0] j,
        input logic [31:0] cols
    );
        return (i * cols) + j;
    endfunction

endpackage
`default_nettype wire

// File: rtl/matrix_result_collector_bitmap.sv
`default_nettype none
// ============================================================================
// Module      : result_bitmap
// Description : Per-element valid bits with a distinct-write counter, a
//               first-write flag for the incoming set and an all-full flag.
// Revision    : 1.0 - initial release
// ============================================================================
module result_bitmap #(
    parameter int DEPTH = 4,
    parameter int IDXW  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            set,
    input  logic [IDXW-1:0] set_idx,
    output logic            first_write,
    output logic            full,
    output logic [31:0]     count
);

    logic [DEPTH-1:0] r_bits;
    logic [31:0]      r_count;

    // A set counts only when the target bit was clear before this edge.
    assign first_write = set && !r_bits[set_idx];
    assign full        = &r_bits;
    assign count       = r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_bits  <= '0;
            r_count <= 32'd0;
        end else begin
            if (set) begin
                r_bits[set_idx] <= 1'b1;
            end
            if (first_write) begin
                r_count <= r_count + 32'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/matrix_result_collector.sv
`default_nettype none
// ============================================================================
// Module      : matrix_result_collector
// Description : Collects (result, i, j) triples in any order into an
//               r_a x c_b buffer, then streams it row-major over valid/ready.
// Revision    : 1.0 - initial release
// ============================================================================
module matrix_result_collector
    import matrix_result_collector_pkg::*;
#(
    parameter int r_a = 2,
    parameter int c_b = 2,
    parameter int W   = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         res_ack,
    input  logic [W-1:0] result,
    input  logic [31:0]  res_i,
    input  logic [31:0]  res_j,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic [31:0]  out_row,
    output logic [31:0]  out_col,
    output logic         out_last,
    output logic         done,
    output logic         err_range,
    output logic         err_late,
    output logic [31:0]  fill_count
);

    localparam int c_depth = r_a * c_b;
    localparam int c_idxw  = (c_depth > 1) ? $clog2(c_depth) : 1;
    localparam logic [c_idxw-1:0] c_last_ptr = c_idxw'(c_depth - 1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [c_idxw-1:0]   r_ptr;
    logic [W-1:0]        r_buf [0:c_depth-1];
    logic                r_err_range;
    logic                r_err_late;

    logic                w_clr;
    logic                w_in_range;
    logic [31:0]         w_idx_full;
    logic [c_idxw-1:0]   w_idx;
    logic                w_wr;
    logic                w_first;
    logic                w_full;
    logic                w_xfer;
    logic                w_ptr_last;
    logic [31:0]         w_ptr32;

    assign w_clr = rst || clear;

    // Bounds are checked on the raw indices before the multiply so that no
    // out-of-range pair can alias an in-range slot.
    assign w_idx_full = mat_idx(res_i, res_j, 32'(c_b));
    assign w_in_range = (res_i < 32'(r_a)) && (res_j < 32'(c_b))
                        && (w_idx_full < 32'(c_depth));
    assign w_idx      = w_idx_full[c_idxw-1:0];
    assign w_wr       = res_ack && (r_state == COLLECT) && w_in_range;

    result_bitmap #(
        .DEPTH (c_depth),
        .IDXW  (c_idxw)
    ) u_bitmap (
        .clk         (clk),
        .rst         (w_clr),
        .set         (w_wr),
        .set_idx     (w_idx),
        .first_write (w_first),
        .full        (w_full),
        .count       (fill_count)
    );

    // Buffer contents after reset are don't-care, so the array has no reset.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_buf[w_idx] <= result;
        end
    end

    assign w_ptr_last = (r_ptr == c_last_ptr);

    always_comb begin
        w_state_nxt = r_state;
        w_xfer      = 1'b0;
        case (r_state)
            COLLECT: begin
                if (w_full) begin
                    w_state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                w_xfer = out_ready;
                if (out_ready && w_ptr_last) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                w_state_nxt = DONE;
            end
            default: begin
                w_state_nxt = COLLECT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_clr) begin
            r_state <= COLLECT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // The pointer parks on the final element rather than running past it.
    always_ff @(posedge clk) begin
        if (w_clr || (r_state == COLLECT)) begin
            r_ptr <= '0;
        end else if (w_xfer && !w_ptr_last) begin
            r_ptr <= r_ptr + c_idxw'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_clr) begin
            r_err_range <= 1'b0;
            r_err_late  <= 1'b0;
        end else begin
            if (res_ack && (r_state == COLLECT) && !w_in_range) begin
                r_err_range <= 1'b1;
            end
            if (res_ack && (r_state != COLLECT)) begin
                r_err_late <= 1'b1;
            end
        end
    end

    assign w_ptr32   = 32'(r_ptr);
    assign out_valid = (r_state == DRAIN);
    assign out_data  = r_buf[r_ptr];
    assign out_row   = w_ptr32 / 32'(c_b);
    assign out_col   = w_ptr32 % 32'(c_b);
    assign out_last  = (r_state == DRAIN) && w_ptr_last;
    assign done      = (r_state == DONE);
    assign err_range = r_err_range;
    assign err_late  = r_err_late;

endmodule
`default_nettype wire
